uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Synthesizable UART transmit controller that shares one serial TX line between NUM_REQ character sources.
- Uses a round-robin grant and an internal bit-period timer.
- Frames are START, 8 data bits LSB first, optional parity, STOP. This is the same framing the bench UART driver produces, so tb_uart_rx-style monitors decode it directly.
- Sits between response/debug character generators and the top-level txd pin of the Programmable Wave Generator.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- CLOCK_RATE, 50_000_000, clk_tx frequency in Hz.
- BAUD_RATE, 57_600, serial bit rate.

Ports:
- clk_tx  in  1  transmit clock.
- rst_clk_tx_n  in  1  asynchronous active-low reset. Assert is asynchronous; deassert must be synchronized externally to clk_tx.
- req_valid  in  NUM_REQ  per-requester character valid.
- req_data  in  8*NUM_REQ  per-requester character; slice i is [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept pulse.
- txd  out  1  serial output; idle high.
- tx_busy  out  1  high while a frame is in flight.
- tx_owner  out  clog2(NUM_REQ)  index of the requester whose frame is in flight.

Behaviour:
- Bit timing:
  - BIT_CLKS = (CLOCK_RATE + BAUD_RATE/2) / BAUD_RATE, computed as a localparam.
  - Bit counter width is clog2(BIT_CLKS).
  - Each bit lasts exactly BIT_CLKS cycles.
- Reset values: txd=1, tx_busy=0, tx_owner=0, req_ready=0, rr_ptr=0, state=IDLE.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - If any req_valid bit is high, grant the first valid index at or after rr_ptr, searching circularly.
  - req_ready[grant] is asserted combinationally in that cycle; this is the accept cycle.
  - On the accept edge: latch the character into shift_reg, set tx_owner=grant, set rr_ptr=(grant+1) mod NUM_REQ, go to START.
- START: txd=0 for BIT_CLKS cycles.
- DATA:
  - txd=shift_reg[0]; shift right at each bit boundary.
  - A 3-bit index counts 0..7; after bit 7 go to PARITY (if enabled) or STOP.
- STOP: txd=1 for BIT_CLKS cycles, then IDLE.
- Latency:
  - txd falls on the first clk_tx edge after the accept cycle.
  - Frame length is 10*BIT_CLKS cycles (11*BIT_CLKS with parity).
  - The earliest next accept is the cycle after STOP completes, so back-to-back frames have zero idle bits.
- tx_busy is high from the edge entering START through the last STOP cycle, inclusive.
- Handshake rules:
  - A requester holds req_valid and req_data stable until it sees req_ready.
  - Dropping req_valid before ready is legal: that request is withdrawn and no frame is sent.
  - req_data is sampled only in the accept cycle; later changes do not affect the frame in flight.
- req_ready is never asserted outside IDLE; requests arriving mid-frame wait.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 frames.
- Single requester: it is granted every frame regardless of rr_ptr.
- Reset mid-frame: txd returns high immediately (asynchronous). The partial frame is abandoned with no resume. rr_ptr returns to 0.
- No requests: remain in IDLE with txd=1.

Optional Feature:
- Macro: UART_TX_ARB_PARITY_EN.
- Defined:
  - The PARITY state is inserted after DATA for one bit period.
  - txd = ^char (even parity: total count of ones in data plus parity is even).
  - Frame becomes 11 bits.
- Undefined:
  - No PARITY state and no parity logic; the frame is exactly 10 bits.

Decomposition:
- Package uart_tx_arb_pkg holds:
  - the state enum localparams (IDLE, START, DATA, PARITY, STOP);
  - the frame-length constant;
  - a BIT_CLKS computation function of (CLOCK_RATE, BAUD_RATE) shared with the receiver.
- One sub-module, uart_tx_rr_arb: combinational round-robin priority select from req_valid and rr_ptr, producing the grant index and a one-hot vector. The owning FSM register-updates rr_ptr.

Test Plan:
Common setup: CLOCK_RATE=1_000_000, BAUD_RATE=100_000, so BIT_CLKS=10.
- Single char: req_valid[0] with 8'h55.
  - req_ready[0] pulses for 1 cycle.
  - txd is low for cycles 1-10 after accept, then 1,0,1,0,1,0,1,0 each for 10 cycles, then high for 10.
  - tx_busy is high for exactly 100 cycles.
- Round-robin: NUM_REQ=3, all valid with 8'h41/8'h42/8'h43, each holding until its ready, then re-asserting.
  - Decoded stream is A,B,C,A,B,C.
  - tx_owner follows 0,1,2,0,1,2.
  - Gap between STOP end and next START is 0 cycles.
- Late request: assert req_valid[1] in the middle of a frame owned by 0.
  - No ready until IDLE.
  - Requester 1 is granted next even though requester 0 is also valid.
- Withdrawal: pulse req_valid[0] for 1 cycle during a frame.
  - No extra frame is sent.
  - req_ready[0] is never asserted for it.
- Reset mid-frame: drive rst_clk_tx_n low during DATA bit 3.
  - txd=1 and tx_busy=0 immediately.
  - After release, the next grant goes to requester 0.
- Parity build (UART_TX_ARB_PARITY_EN defined), char 8'h07.
  - Parity bit is 1; the frame is 110 cycles.
  - With 8'h03 the parity bit is 0.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arb_pkg
// Shared definitions for the arbitrated UART transmitter:
//   - tx_state_e : frame sequencer states (IDLE, START, DATA, PARITY, STOP)
//   - FRAME_BITS : bits per frame (10, or 11 with UART_TX_ARB_PARITY_EN)
//   - calc_bit_clks() : clocks per bit, rounded to nearest; also used by the
//     matching receiver so both ends agree on the bit period
//   - even_parity()   : parity bit that makes the total count of ones even
// Optional feature macro: UART_TX_ARB_PARITY_EN
// -----------------------------------------------------------------------------
package uart_tx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int DATA_BITS = 32'sd8;

`ifdef UART_TX_ARB_PARITY_EN
    localparam int FRAME_BITS = 32'sd11;
`else
    localparam int FRAME_BITS = 32'sd10;
`endif

    // Round to the nearest whole number of clocks per bit.
    function automatic int calc_bit_clks(input int clock_rate, input int baud_rate);
        return (clock_rate + (baud_rate / 32'sd2)) / baud_rate;
    endfunction

    // XOR of the data gives the bit that makes data+parity have even weight.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_rr_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_rr_arb
// Combinational round-robin select. Picks the first asserted req_valid bit at
// or after rr_ptr, wrapping circularly. The pointer itself is owned and
// updated by the caller.
// Ports:
//   req_valid    in  NUM_REQ  per-requester valid
//   rr_ptr       in  IDX_W    highest-priority index this cycle
//   grant_valid  out 1        at least one requester is valid
//   grant_idx    out IDX_W    winning index (0 when grant_valid is low)
//   grant_onehot out NUM_REQ  one-hot form of grant_idx (zero when no grant)
// -----------------------------------------------------------------------------
module uart_tx_rr_arb #(
    parameter int NUM_REQ = 32'sd2,
    parameter int IDX_W   = (NUM_REQ > 32'sd1) ? $clog2(NUM_REQ) : 32'sd1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [NUM_REQ-1:0] grant_onehot
);

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Circular priority scan: the first hit at increasing offset from rr_ptr wins.
    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        cand_s       = '0;
        hit_s        = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s      = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            hit_s       = !grant_valid && req_valid[cand_s];
            grant_idx   = hit_s ? cand_s : grant_idx;
            grant_valid = grant_valid | hit_s;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_onehot[i] = grant_valid && (int'(grant_idx) == i);
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
// UART transmitter shared by NUM_REQ character sources. A round-robin grant
// picks one source while idle; its character goes out as START, 8 data bits
// LSB first, optional even parity, STOP. Each bit lasts BIT_CLKS clocks.
// Optional feature macro: UART_TX_ARB_PARITY_EN (adds the parity bit).
// Ports:
//   clk_tx        in  1          transmit clock
//   rst_clk_tx_n  in  1          async active-low reset (sync deassert outside)
//   req_valid     in  NUM_REQ    per-requester character valid
//   req_data      in  8*NUM_REQ  per-requester character, slice i = [8i+7:8i]
//   req_ready     out NUM_REQ    one-hot accept, combinational, IDLE only
//   txd           out 1          serial line, idle high
//   tx_busy       out 1          high while a frame is in flight
//   tx_owner      out clog2(NUM_REQ) requester owning the frame in flight
// -----------------------------------------------------------------------------
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ    = 32'sd2,
    parameter int CLOCK_RATE = 32'sd50_000_000,
    parameter int BAUD_RATE  = 32'sd57_600
) (
    input  logic                       clk_tx,
    input  logic                       rst_clk_tx_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       txd,
    output logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] tx_owner
);

    localparam int BIT_CLKS = calc_bit_clks(CLOCK_RATE, BAUD_RATE);
    localparam int CNT_W    = ($clog2(BIT_CLKS) < 32'sd1) ? 32'sd1 : $clog2(BIT_CLKS);
    localparam int IDX_W    = $clog2(NUM_REQ);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CLKS - 32'sd1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 32'sd1);

    tx_state_e          state_r,  state_s;
    logic [CNT_W-1:0]   cnt_r,    cnt_s;
    logic [2:0]         idx_r,    idx_s;
    logic [7:0]         shift_r,  shift_s;
    logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s;
    logic [IDX_W-1:0]   owner_r,  owner_s;
    logic               txd_r,    txd_s;
    logic               busy_r,   busy_s;
    logic [NUM_REQ-1:0] req_ready_s;
`ifdef UART_TX_ARB_PARITY_EN
    logic               par_r,    par_s;
`endif

    logic               grant_valid_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic [NUM_REQ-1:0] grant_onehot_s;
    logic [7:0]         grant_char_s;
    logic               bit_end_s;

    uart_tx_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .req_valid    (req_valid),
        .rr_ptr       (rr_ptr_r),
        .grant_valid  (grant_valid_s),
        .grant_idx    (grant_idx_s),
        .grant_onehot (grant_onehot_s)
    );

    assign grant_char_s = req_data[{grant_idx_s, 3'b000} +: 8];
    assign bit_end_s    = (cnt_r == LAST_CNT);

    // Frame sequencer next state, plus txd/busy computed from the next state so
    // the registered outputs line up exactly with the state they describe.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        idx_s       = idx_r;
        shift_s     = shift_r;
        rr_ptr_s    = rr_ptr_r;
        owner_s     = owner_r;
        req_ready_s = '0;
        txd_s       = 1'b1;
        busy_s      = 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
        par_s       = par_r;
`endif
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    req_ready_s = grant_onehot_s;
                    state_s     = START;
                    cnt_s       = '0;
                    idx_s       = 3'd0;
                    shift_s     = grant_char_s;
                    owner_s     = grant_idx_s;
                    rr_ptr_s    = (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + IDX_W'(1);
`ifdef UART_TX_ARB_PARITY_EN
                    par_s       = even_parity(grant_char_s);
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_s = DATA;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    cnt_s   = '0;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (idx_r == 3'd7) begin
                        idx_s   = 3'd0;
`ifdef UART_TX_ARB_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
`ifdef UART_TX_ARB_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    state_s = STOP;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end_s) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
                idx_s   = 3'd0;
            end
        endcase

        case (state_s)
            IDLE:    txd_s = 1'b1;
            START:   txd_s = 1'b0;
            DATA:    txd_s = shift_s[0];
`ifdef UART_TX_ARB_PARITY_EN
            PARITY:  txd_s = par_s;
`endif
            STOP:    txd_s = 1'b1;
            default: txd_s = 1'b1;
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and output registers; reset drops txd high at once, abandoning any frame.
    always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
        if (!rst_clk_tx_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            idx_r    <= 3'd0;
            shift_r  <= 8'h00;
            rr_ptr_r <= '0;
            owner_r  <= '0;
            txd_r    <= 1'b1;
            busy_r   <= 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
            par_r    <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            idx_r    <= idx_s;
            shift_r  <= shift_s;
            rr_ptr_r <= rr_ptr_s;
            owner_r  <= owner_s;
            txd_r    <= txd_s;
            busy_r   <= busy_s;
`ifdef UART_TX_ARB_PARITY_EN
            par_r    <= par_s;
`endif
        end
    end

    assign req_ready = req_ready_s;
    assign txd       = txd_r;
    assign tx_busy   = busy_r;
    assign tx_owner  = owner_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
// Bench for uart_tx_arb with NUM_REQ=3 and BIT_CLKS=10. A frame-level model
// (queue of expected line levels per cycle plus a round-robin pointer) is
// compared against the DUT on every falling clock edge; a mid-bit UART
// decoder and directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

    localparam int NREQ     = 3;
    localparam int BIT_CLKS = 10;          // (1_000_000 + 50_000) / 100_000
`ifdef UART_TX_ARB_PARITY_EN
    localparam int FBITS    = 11;
`else
    localparam int FBITS    = 10;
`endif
    localparam int FRAME_CLKS = FBITS * BIT_CLKS;

    logic            clk_tx       = 1'b0;
    logic            rst_clk_tx_n = 1'b0;
    logic [2:0]      req_valid    = 3'b000;
    logic [23:0]     req_data     = 24'h000000;
    logic [2:0]      req_ready;
    logic            txd;
    logic            tx_busy;
    logic [1:0]      tx_owner;

    int checks = 0;
    int errors = 0;

    uart_tx_arb #(
        .NUM_REQ    (NREQ),
        .CLOCK_RATE (1_000_000),
        .BAUD_RATE  (100_000)
    ) dut (
        .clk_tx       (clk_tx),
        .rst_clk_tx_n (rst_clk_tx_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .txd          (txd),
        .tx_busy      (tx_busy),
        .tx_owner     (tx_owner)
    );

    always #5 clk_tx = ~clk_tx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic exp_q[$];
    int   m_rr    = 0;
    int   m_owner = 0;
    int   rdy_cnt[NREQ];

    function automatic int pick(input logic [2:0] v, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (rr + k) % NREQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic push_frame(input logic [7:0] d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_ARB_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) repeat (BIT_CLKS) exp_q.push_back(bits[i]);
    endtask

    always @(negedge clk_tx) begin
        int g;
        logic e;
        if (!rst_clk_tx_n) begin
            exp_q.delete();
            m_rr = 0;
            check("rst_txd", {31'd0, txd}, 32'd1);
            check("rst_busy", {31'd0, tx_busy}, 32'd0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("txd", {31'd0, txd}, {31'd0, e});
            check("busy", {31'd0, tx_busy}, 32'd1);
            check("owner", {30'd0, tx_owner}, m_owner);
            check("ready_mid", {29'd0, req_ready}, 32'd0);
        end else begin
            check("idle_txd", {31'd0, txd}, 32'd1);
            check("idle_busy", {31'd0, tx_busy}, 32'd0);
            g = pick(req_valid, m_rr);
            check("ready", {29'd0, req_ready}, (g >= 0) ? (32'd1 << g) : 32'd0);
            if (g >= 0) begin
                push_frame(req_data[g*8 +: 8]);
                m_owner = g;
                m_rr    = (g + 1) % NREQ;
            end
        end
        if (rst_clk_tx_n) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) rdy_cnt[i]++;
        end
    end

    // ---------------- mid-bit line decoder ----------------
    logic [7:0] rx_q[$];
    logic       rx_par_q[$];
    logic [7:0] rx_sh = 8'h00;
    int         rx_cnt = -1;

    always @(negedge clk_tx) begin
        if (!rst_clk_tx_n) begin
            rx_cnt = -1;
        end else if (rx_cnt < 0) begin
            if (txd == 1'b0) rx_cnt = 0;
        end else begin
            rx_cnt++;
            if ((rx_cnt % BIT_CLKS) == 5 && (rx_cnt / BIT_CLKS) >= 1 && (rx_cnt / BIT_CLKS) <= 8)
                rx_sh[rx_cnt / BIT_CLKS - 1] = txd;
            if (rx_cnt == 9 * BIT_CLKS + 5 && FBITS == 11) rx_par_q.push_back(txd);
            if (rx_cnt == (FBITS - 1) * BIT_CLKS + 5) begin
                rx_q.push_back(rx_sh);
                rx_cnt = -1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready(output int idx);
        idx = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_tx);
            if (req_ready != 3'b000) begin
                for (int j = 0; j < NREQ; j++) if (req_ready[j]) idx = j;
                break;
            end
        end
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: got no req_ready within 400 cycles, expected a grant");
        end
    endtask

    task automatic frame_len(output int n, output logic first_txd);
        n = 0;
        first_txd = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_tx);
            if (tx_busy) begin
                if (n == 0) first_txd = txd;
                n++;
            end else if (n > 0) begin
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk_tx); #1;
        req_valid    = 3'b000;
        rst_clk_tx_n = 1'b0;
        repeat (3) @(posedge clk_tx);
        #1 rst_clk_tx_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n;
        int c0;
        logic ft;
        int   grant_log[6];
        int   exp_log[6]    = '{0, 1, 2, 0, 1, 2};
        logic [7:0] exp_rr[6] = '{8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43};

        // Reset state
        repeat (3) @(negedge clk_tx);
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_owner", {30'd0, tx_owner}, 32'd0);
        check("reset_ready", {29'd0, req_ready}, 32'd0);
        @(posedge clk_tx); #1 rst_clk_tx_n = 1'b1;

        // Single character 8'h55 from requester 0
        @(posedge clk_tx); #1;
        req_valid = 3'b001; req_data[7:0] = 8'h55;
        wait_ready(idx);
        check("single_grant", idx, 32'd0);
        @(posedge clk_tx); #1 req_valid = 3'b000;
        frame_len(n, ft);
        check("single_busy_len", n, FRAME_CLKS);
        check("single_first_txd", {31'd0, ft}, 32'd0);
        check("single_ready_pulses", rdy_cnt[0], 32'd1);
        check("single_rx_n", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("single_rx", {24'd0, rx_q.pop_front()}, 32'h55);

        // Round robin, all three continuously valid
        do_reset();
        rx_q.delete();
        req_data = {8'h43, 8'h42, 8'h41};
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            wait_ready(idx);
            grant_log[k] = idx;
        end
        @(posedge clk_tx); #1 req_valid = 3'b000;
        frame_len(n, ft);
        for (int k = 0; k < 6; k++) check("rr_grant", grant_log[k], exp_log[k]);
        check("rr_rx_n", rx_q.size(), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (rx_q.size() > 0) check("rr_rx", {24'd0, rx_q.pop_front()}, {24'd0, exp_rr[k]});
        end

        // Late request from 1 while 0 keeps requesting
        rx_q.delete();
        @(posedge clk_tx); #1;
        req_valid = 3'b001; req_data[7:0] = 8'h10;
        wait_ready(idx);
        check("late_first", idx, 32'd0);
        @(posedge clk_tx); #1 req_data[7:0] = 8'h20;
        repeat (30) @(posedge clk_tx);
        #1 req_valid[1] = 1'b1; req_data[15:8] = 8'h31;
        wait_ready(idx);
        check("late_grant", idx, 32'd1);
        @(posedge clk_tx); #1 req_valid = 3'b000;
        frame_len(n, ft);
        check("late_rx_n", rx_q.size(), 32'd2);
        if (rx_q.size() > 1) begin
            check("late_rx0", {24'd0, rx_q.pop_front()}, 32'h10);
            check("late_rx1", {24'd0, rx_q.pop_front()}, 32'h31);
        end

        // Withdrawal of a one-cycle request mid-frame
        rx_q.delete();
        c0 = rdy_cnt[0];
        @(posedge clk_tx); #1;
        req_valid = 3'b100; req_data[23:16] = 8'hA5;
        wait_ready(idx);
        check("wd_grant", idx, 32'd2);
        @(posedge clk_tx); #1 req_valid = 3'b000;
        repeat (30) @(posedge clk_tx);
        #1 req_valid[0] = 1'b1; req_data[7:0] = 8'hFF;
        @(posedge clk_tx); #1 req_valid[0] = 1'b0;
        frame_len(n, ft);
        repeat (30) @(negedge clk_tx);
        check("wd_no_ready0", rdy_cnt[0], c0);
        check("wd_busy", {31'd0, tx_busy}, 32'd0);
        check("wd_rx_n", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("wd_rx", {24'd0, rx_q.pop_front()}, 32'hA5);

        // Reset during data bit 3 of a frame from requester 1
        rx_q.delete();
        @(posedge clk_tx); #1;
        req_valid = 3'b010; req_data[15:8] = 8'h55;
        wait_ready(idx);
        check("rm_single_grant", idx, 32'd1);
        @(posedge clk_tx); #1;
        req_valid = 3'b101; req_data[7:0] = 8'h0F; req_data[23:16] = 8'h22;
        repeat (44) @(posedge clk_tx);
        #1 check("rm_bit3_low", {31'd0, txd}, 32'd0);
        rst_clk_tx_n = 1'b0;
        #1;
        check("rm_txd_high", {31'd0, txd}, 32'd1);
        check("rm_busy_low", {31'd0, tx_busy}, 32'd0);
        repeat (3) @(posedge clk_tx);
        #1 rst_clk_tx_n = 1'b1;
        wait_ready(idx);
        check("rm_post_grant", idx, 32'd0);
        @(posedge clk_tx); #1 req_valid = 3'b000;
        frame_len(n, ft);
        check("rm_rx_n", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("rm_rx", {24'd0, rx_q.pop_front()}, 32'h0F);

        // Back-to-back 8'h07 then 8'h03; parity bits when enabled
        rx_q.delete();
        rx_par_q.delete();
        @(posedge clk_tx); #1;
        req_valid = 3'b001; req_data[7:0] = 8'h07;
        wait_ready(idx);
        check("par_grant", idx, 32'd0);
        @(posedge clk_tx); #1 req_data[7:0] = 8'h03;
        frame_len(n, ft);
        check("par_len0", n, FRAME_CLKS);
        check("accept_after_stop", {29'd0, req_ready}, 32'd1);
        @(posedge clk_tx); #1 req_valid = 3'b000;
        frame_len(n, ft);
        check("par_len1", n, FRAME_CLKS);
        check("par_rx_n", rx_q.size(), 32'd2);
        if (rx_q.size() > 1) begin
            check("par_rx0", {24'd0, rx_q.pop_front()}, 32'h07);
            check("par_rx1", {24'd0, rx_q.pop_front()}, 32'h03);
        end
`ifdef UART_TX_ARB_PARITY_EN
        check("par_bits_n", rx_par_q.size(), 32'd2);
        if (rx_par_q.size() > 1) begin
            check("par_bit07", {31'd0, rx_par_q.pop_front()}, 32'd1);
            check("par_bit03", {31'd0, rx_par_q.pop_front()}, 32'd0);
        end
`endif

        repeat (5) @(negedge clk_tx);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
